// File: rtl/access_arbiter_n.sv
// Round-robin access arbiter: one user at a time is checked against a permission table and then granted or denied; outputs are valid 2 edges after the request is sampled.
// No backpressure: requests are only looked at in IDLE, and a held request is re-arbitrated after each grant or denial.
module access_arbiter_n #(
  parameter int N_USERS = 2,
  parameter int AUTH_W = 3,
  parameter int HOLD_CYCLES = 16,
  parameter logic [(2**AUTH_W)*7-1:0] PERM_MASK =
    56'b1111111_0111111_0011111_0001111_0000111_0000011_0000001_0000000,
  parameter logic [2**AUTH_W-1:0] OUT_SEL_MASK = 8'hF0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [N_USERS*AUTH_W-1:0]   USER_AUTH,
  input  logic [N_USERS-1:0]          USER_FUNC,
  input  logic [2*N_USERS-1:0]        USER_BTN,
  input  logic [N_USERS-1:0]          USER_REQ,
  output logic [N_USERS-1:0]          GRANT,
  output logic                        BUSY,
  output logic                        DENY,
  output logic [6:0]                  OUT_LEDS,
  output logic [7:0]                  OUT_MLEDS,
  output logic [7:0]                  OUT_SEGS,
  output logic [3:0]                  AC_7SEG
);

  localparam int IDX_W = 2;
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_GRANT, S_DENY} state_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  idx_q;
  logic [AUTH_W-1:0] auth_q;
  logic [2:0]        code_q;
  logic [CNT_W-1:0]  cnt;

  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [AUTH_W-1:0] sel_auth;
  logic [2:0]        sel_code;
  logic [7:0]        perm_row;
  logic              perm_ok;
  logic [IDX_W-1:0]  next_ptr;
  logic [N_USERS-1:0] gnt_val;
  logic [3:0]        ac_val;
  logic [6:0]        led_val;
  logic [7:0]        mled_val;
  logic [7:0]        seg_val;
  logic              route_led;

  function automatic logic [7:0] seg_of(input logic [2:0] d);
    case (d)
      3'd0:    seg_of = 8'hC0;
      3'd1:    seg_of = 8'hF9;
      3'd2:    seg_of = 8'hA4;
      3'd3:    seg_of = 8'hB0;
      3'd4:    seg_of = 8'h99;
      3'd5:    seg_of = 8'h92;
      3'd6:    seg_of = 8'h82;
      default: seg_of = 8'hF8;
    endcase
  endfunction

  // First requester at or after the pointer, wrapping around
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N_USERS; k++) begin
      if (!sel_found && USER_REQ[(int'(ptr) + k) % N_USERS]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'((int'(ptr) + k) % N_USERS);
      end
    end
  end

  always_comb begin
    sel_auth = USER_AUTH[int'(sel_idx)*AUTH_W +: AUTH_W];
    sel_code = {USER_FUNC[int'(sel_idx)],
                ~USER_BTN[2*int'(sel_idx)+1],
                ~USER_BTN[2*int'(sel_idx)]};
  end

  // Code 0 never reaches the table lookup; the padding bit keeps the index in range
  always_comb begin
    perm_row  = {1'b0, PERM_MASK[int'(auth_q)*7 +: 7]};
    perm_ok   = (code_q != 3'd0) && perm_row[code_q - 3'd1];
    next_ptr  = (idx_q == IDX_W'(N_USERS - 1)) ? '0 : idx_q + IDX_W'(1);
    gnt_val   = N_USERS'(1) << idx_q;
    ac_val    = ~(4'b0001 << idx_q);
    led_val   = 7'(1) << (code_q - 3'd1);
    mled_val  = 8'(1) << code_q;
    seg_val   = seg_of(3'(auth_q));
    route_led = OUT_SEL_MASK[auth_q];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      ptr       <= '0;
      idx_q     <= '0;
      auth_q    <= '0;
      code_q    <= '0;
      cnt       <= '0;
      BUSY      <= 1'b0;
      DENY      <= 1'b0;
      GRANT     <= '0;
      OUT_LEDS  <= '0;
      OUT_MLEDS <= '0;
      OUT_SEGS  <= 8'hFF;
      AC_7SEG   <= 4'hF;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            idx_q  <= sel_idx;
            auth_q <= sel_auth;
            code_q <= sel_code;
            BUSY   <= 1'b1;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (perm_ok) begin
            state    <= S_GRANT;
            cnt      <= '0;
            GRANT    <= gnt_val;
            AC_7SEG  <= ac_val;
            OUT_SEGS <= seg_val;
            if (route_led) OUT_LEDS <= led_val;
            else           OUT_MLEDS <= mled_val;
          end else begin
            state <= S_DENY;
            DENY  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            state     <= S_IDLE;
            ptr       <= next_ptr;
            BUSY      <= 1'b0;
            GRANT     <= '0;
            OUT_LEDS  <= '0;
            OUT_MLEDS <= '0;
            OUT_SEGS  <= 8'hFF;
            AC_7SEG   <= 4'hF;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DENY: begin
          state <= S_IDLE;
          ptr   <= next_ptr;
          BUSY  <= 1'b0;
          DENY  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_access_arbiter_n.sv
// Bench for access_arbiter_n with default parameters: directed scenarios plus random traffic
// checked against a transaction-level model of arbitration, permission and display rules.
module tb_access_arbiter_n;

  localparam int HOLD = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] USER_AUTH;
  logic [1:0] USER_FUNC;
  logic [3:0] USER_BTN;
  logic [1:0] USER_REQ;
  logic [1:0] GRANT;
  logic       BUSY;
  logic       DENY;
  logic [6:0] OUT_LEDS;
  logic [7:0] OUT_MLEDS;
  logic [7:0] OUT_SEGS;
  logic [3:0] AC_7SEG;

  access_arbiter_n dut (
    .CLK(CLK), .RST(RST),
    .USER_AUTH(USER_AUTH), .USER_FUNC(USER_FUNC), .USER_BTN(USER_BTN), .USER_REQ(USER_REQ),
    .GRANT(GRANT), .BUSY(BUSY), .DENY(DENY),
    .OUT_LEDS(OUT_LEDS), .OUT_MLEDS(OUT_MLEDS), .OUT_SEGS(OUT_SEGS), .AC_7SEG(AC_7SEG)
  );

  always #5 CLK = ~CLK;

  wire [30:0] obs = {GRANT, DENY, BUSY, OUT_LEDS, OUT_MLEDS, OUT_SEGS, AC_7SEG};

  int total = 0;
  int bad = 0;
  int ptr = 0;
  logic [7:0] seg_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  function automatic logic [30:0] idle_vec(input logic busy, input logic deny);
    return {2'b00, deny, busy, 7'd0, 8'd0, 8'hFF, 4'hF};
  endfunction

  // Expected outputs while a grant is held: auths 4..7 go to the LEDs, 0..3 to the matrix
  function automatic logic [30:0] grant_vec(input int idx, input int a, input int c);
    logic [1:0] g;
    logic [6:0] l;
    logic [7:0] m;
    logic [3:0] ac;
    g  = 2'(1 << idx);
    ac = ~4'(1 << idx);
    if (a >= 4) begin
      l = 7'(1 << (c - 1));
      m = 8'd0;
    end else begin
      l = 7'd0;
      m = 8'(1 << c);
    end
    return {g, 1'b0, 1'b1, l, m, seg_tab[a % 8], ac};
  endfunction

  // Runs one transaction from an IDLE negedge. keep=0 scrambles all inputs and drops
  // the requests right after sampling; abort>0 returns early inside GRANT/DENY.
  task automatic do_txn(input string name, input logic [1:0] req, input logic [5:0] auth,
                        input logic [1:0] func, input logic [3:0] btn,
                        input bit keep, input int abort);
    int idx, a, c;
    bit ok;
    logic [30:0] exp;
    idx = -1;
    for (int k = 0; k < 2; k++)
      if (idx < 0 && req[(ptr + k) % 2]) idx = (ptr + k) % 2;
    a  = int'(auth[idx*3 +: 3]);
    c  = int'({func[idx], ~btn[2*idx+1], ~btn[2*idx]});
    ok = (c != 0) && (c <= a);
    USER_REQ = req; USER_AUTH = auth; USER_FUNC = func; USER_BTN = btn;
    @(posedge CLK);
    if (!keep) begin
      #1;
      USER_AUTH = 6'($urandom); USER_FUNC = 2'($urandom);
      USER_BTN = 4'($urandom); USER_REQ = 2'b00;
    end
    @(negedge CLK);
    total++;
    if (obs !== idle_vec(1'b1, 1'b0)) begin
      bad++;
      $display("FAIL %s check_phase: got %h want %h", name, obs, idle_vec(1'b1, 1'b0));
    end
    @(negedge CLK);
    if (ok) begin
      exp = grant_vec(idx, a, c);
      for (int cyc = 1; cyc <= HOLD; cyc++) begin
        total++;
        if (obs !== exp) begin
          bad++;
          $display("FAIL %s grant_cycle%0d: got %h want %h (user %0d auth %0d code %0d)",
                   name, cyc, obs, exp, idx, a, c);
        end
        if (abort > 0 && cyc == abort) return;
        @(negedge CLK);
      end
    end else begin
      total++;
      if (obs !== idle_vec(1'b1, 1'b1)) begin
        bad++;
        $display("FAIL %s deny_pulse: got %h want %h (user %0d auth %0d code %0d)",
                 name, obs, idle_vec(1'b1, 1'b1), idx, a, c);
      end
      if (abort > 0) return;
      @(negedge CLK);
    end
    total++;
    if (obs !== idle_vec(1'b0, 1'b0)) begin
      bad++;
      $display("FAIL %s back_to_idle: got %h want %h", name, obs, idle_vec(1'b0, 1'b0));
    end
    ptr = (idx + 1) % 2;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    USER_REQ = 2'b11; USER_AUTH = 6'o77; USER_FUNC = 2'b00; USER_BTN = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      total++;
      if (obs !== idle_vec(1'b0, 1'b0)) begin
        bad++;
        $display("FAIL reset_state%0d: got %h want %h", i, obs, idle_vec(1'b0, 1'b0));
      end
    end
    USER_REQ = 2'b00; USER_BTN = 4'b1111;
    RST = 1'b0;
    ptr = 0;
    @(negedge CLK);
  endtask

  task automatic test_led_grant();
    do_txn("led_grant", 2'b01, {3'd0, 3'd5}, 2'b00, 4'b1100, 1'b0, 0);
  endtask

  task automatic test_deny();
    do_txn("deny", 2'b10, {3'd2, 3'd0}, 2'b10, 4'b1111, 1'b0, 0);
  endtask

  task automatic test_matrix();
    do_txn("matrix", 2'b11, {3'd7, 3'd3}, 2'b10, 4'b0010, 1'b0, 0);
  endtask

  task automatic test_code0();
    do_txn("code0", 2'b01, {3'd0, 3'd7}, 2'b00, 4'b1111, 1'b0, 0);
    do_txn("latch", 2'b01, {3'd0, 3'd1}, 2'b00, 4'b1110, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_txn("back_to_back", 2'b11, {3'd7, 3'd7}, 2'b10, 4'b1000, 1'b1, 0);
    USER_REQ = 2'b00;
    @(negedge CLK);
    total++;
    if (obs !== idle_vec(1'b0, 1'b0)) begin
      bad++;
      $display("FAIL b2b_release: got %h want %h", obs, idle_vec(1'b0, 1'b0));
    end
  endtask

  task automatic test_reset_mid();
    do_txn("rst_grant", 2'b11, {3'd7, 3'd7}, 2'b10, 4'b1000, 1'b1, 5);
    RST = 1'b1;
    @(negedge CLK);
    total++;
    if (obs !== idle_vec(1'b0, 1'b0)) begin
      bad++;
      $display("FAIL reset_mid_grant: got %h want %h", obs, idle_vec(1'b0, 1'b0));
    end
    RST = 1'b0;
    ptr = 0;
    do_txn("rst_deny", 2'b11, {3'd7, 3'd7}, 2'b10, 4'b0011, 1'b1, 1);
    RST = 1'b1;
    @(negedge CLK);
    total++;
    if (obs !== idle_vec(1'b0, 1'b0)) begin
      bad++;
      $display("FAIL reset_mid_deny: got %h want %h", obs, idle_vec(1'b0, 1'b0));
    end
    RST = 1'b0;
    ptr = 0;
    do_txn("after_reset", 2'b11, {3'd7, 3'd7}, 2'b10, 4'b1000, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      do_txn("random", 2'($urandom_range(1, 3)), 6'($urandom), 2'($urandom),
             4'($urandom), ($urandom_range(0, 3) == 0), 0);
    USER_REQ = 2'b00;
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    USER_AUTH = '0; USER_FUNC = '0; USER_BTN = 4'b1111; USER_REQ = '0;
    @(negedge CLK);
    test_reset();
    test_led_grant();
    test_deny();
    test_matrix();
    test_code0();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
